// File: rtl/fetch_unit_nwide_if.sv
// rtl/fetch_unit_nwide_if.sv - I-cache, redirect and dispatch bundle for fetch_unit_nwide
interface fetch_unit_nwide_if #(
  parameter int FETCH_WIDTH = 3,
  parameter int DISP_WIDTH  = 3,
  parameter int FQ_DEPTH    = 8,
  parameter int XLEN        = 32
);
  logic                              take_branch;
  logic [XLEN-1:0]                   target_pc;
  logic [FETCH_WIDTH*XLEN-1:0]       icache_addr;
  logic [FETCH_WIDTH*32-1:0]         icache_data;
  logic [FETCH_WIDTH-1:0]            icache_valid;
  logic [$clog2(DISP_WIDTH+1)-1:0]   disp_ready;
  logic [DISP_WIDTH-1:0]             disp_valid;
  logic [DISP_WIDTH*32-1:0]          disp_inst;
  logic [DISP_WIDTH*XLEN-1:0]        disp_pc;
  logic [$clog2(FQ_DEPTH+1)-1:0]     fq_count;
  logic                              fetch_stall;

  modport master (
    input  take_branch, target_pc, icache_data, icache_valid, disp_ready,
    output icache_addr, disp_valid, disp_inst, disp_pc, fq_count, fetch_stall
  );

  modport slave (
    output take_branch, target_pc, icache_data, icache_valid, disp_ready,
    input  icache_addr, disp_valid, disp_inst, disp_pc, fq_count, fetch_stall
  );
endinterface

// File: rtl/fetch_unit_nwide.sv
// rtl/fetch_unit_nwide.sv - N-wide fetch unit with circular fetch queue; FQ_BYPASS_EN enables zero-latency bypass
module fetch_unit_nwide #(
  parameter int              FETCH_WIDTH = 3,
  parameter int              DISP_WIDTH  = 3,
  parameter int              FQ_DEPTH    = 8,
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input logic                clock,
  input logic                reset,
  fetch_unit_nwide_if.master bus
);
  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = $clog2(FQ_DEPTH + 1);
`ifdef FQ_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic [XLEN-1:0]  pc;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [31:0]      fq_inst [FQ_DEPTH];
  logic [XLEN-1:0]  fq_pc   [FQ_DEPTH];

  int  p;           // contiguous hit prefix length
  int  free_slots;
  int  v;           // valid dispatch lanes from the FQ
  int  d;           // entries dequeued
  int  k;           // lanes enqueued
  int  skip;        // hit lanes consumed directly by the bypass
  int  ready;
  logic bypass;

  always_comb begin
    p = 0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (bus.icache_valid[i] && p == i) p = i + 1;
    end
    free_slots = FQ_DEPTH - int'(count);
    ready      = int'(bus.disp_ready);
    v          = (int'(count) < DISP_WIDTH) ? int'(count) : DISP_WIDTH;
    bypass     = BYPASS_EN && (count == '0) && !bus.take_branch;
    skip       = 0;
    d          = 0;
    k          = 0;
    if (!bus.take_branch) begin
      if (bypass) begin
        skip = (p < DISP_WIDTH) ? p : DISP_WIDTH;
        skip = (ready < skip) ? ready : skip;
      end else begin
        d = (ready < v) ? ready : v;
      end
      k = ((p - skip) < free_slots) ? (p - skip) : free_slots;
    end
    bus.fetch_stall = !bus.take_branch && (p > free_slots);
    bus.fq_count    = count;
  end

  always_comb begin
    bus.disp_valid = '0;
    bus.disp_inst  = '0;
    bus.disp_pc    = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      bus.icache_addr[i*XLEN +: XLEN] = pc + XLEN'(4 * i);
    end
    for (int i = 0; i < DISP_WIDTH; i++) begin
      if (bypass) begin
        // Empty FQ: present the raw hit lanes this cycle instead of waiting a cycle
        bus.disp_valid[i] = (i < p);
        if (i < p) begin
          bus.disp_inst[i*32 +: 32]     = bus.icache_data[i*32 +: 32];
          bus.disp_pc[i*XLEN +: XLEN]   = pc + XLEN'(4 * i);
        end
      end else begin
        bus.disp_valid[i]             = !bus.take_branch && (i < v);
        bus.disp_inst[i*32 +: 32]     = fq_inst[PTR_W'(int'(head) + i)];
        bus.disp_pc[i*XLEN +: XLEN]   = fq_pc[PTR_W'(int'(head) + i)];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.take_branch) begin
      pc    <= bus.target_pc;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      pc    <= pc + XLEN'(4 * (skip + k));
      head  <= PTR_W'(int'(head) + d);
      tail  <= PTR_W'(int'(tail) + k);
      count <= CNT_W'(int'(count) + k - d);
    end
  end

  // Storage is not reset; occupancy alone decides what is visible
  always_ff @(posedge clock) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!reset && !bus.take_branch && i < k) begin
        fq_inst[PTR_W'(int'(tail) + i)] <= bus.icache_data[(i + skip)*32 +: 32];
        fq_pc[PTR_W'(int'(tail) + i)]   <= pc + XLEN'(4 * (i + skip));
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit_nwide.sv
// tb/tb_fetch_unit_nwide.sv - scoreboard bench for fetch_unit_nwide
module tb_fetch_unit_nwide;
  localparam int FW = 3, DW = 3, DEPTH = 8, XLEN = 32;
`ifdef FQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fetch_unit_nwide_if #(.FETCH_WIDTH(FW), .DISP_WIDTH(DW), .FQ_DEPTH(DEPTH), .XLEN(XLEN)) bus ();
  fetch_unit_nwide #(.FETCH_WIDTH(FW), .DISP_WIDTH(DW), .FQ_DEPTH(DEPTH), .XLEN(XLEN),
                     .RESET_PC(32'h0)) dut (.clock(clock), .reset(reset), .bus(bus));

  ent_t        sb[$];
  logic [31:0] m_pc;
  int          m_count;
  int          passes = 0, fails = 0, total = 0;
  logic [31:0] last_pc;
  bit          track;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00005A5A;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [2:0] mask(input int n);
    return (n >= 3) ? 3'b111 : (n == 2) ? 3'b011 : (n == 1) ? 3'b001 : 3'b000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic note_disp(input logic [31:0] a);
    if (track) chk("seq_pc", a, last_pc + 32'd4);
    last_pc = a;
    track   = 1'b1;
  endtask

  task automatic model_reset(input logic [31:0] a);
    sb.delete();
    m_count = 0;
    m_pc    = a;
    track   = 1'b0;
  endtask

  // Drive one cycle, check outputs mid-cycle, advance the model, end 1 time unit after the edge
  task automatic cycle(input logic [2:0] valid, input int rdy, input bit br, input logic [31:0] tgt);
    int p, free_n, v, d, k, b, skip;
    ent_t e;
    bus.icache_valid = valid;
    bus.disp_ready   = 2'(rdy);
    bus.take_branch  = br;
    bus.target_pc    = tgt;
    for (int i = 0; i < FW; i++) bus.icache_data[i*32 +: 32] = inst_of(m_pc + 32'(4 * i));
    #4;
    p      = valid[0] ? (valid[1] ? (valid[2] ? 3 : 2) : 1) : 0;
    free_n = DEPTH - m_count;
    for (int i = 0; i < FW; i++) chk($sformatf("icache_addr%0d", i), bus.icache_addr[i*32 +: 32], m_pc + 32'(4 * i));
    chk("fq_count", bus.fq_count, m_count);
    chk("fetch_stall", bus.fetch_stall, !br && (p > free_n));
    if (br) begin
      chk("disp_valid_br", bus.disp_valid, 3'b000);
      model_reset(tgt);
    end else if (BYP && m_count == 0) begin
      b = imin(p, DW);
      chk("disp_valid_byp", bus.disp_valid, mask(b));
      for (int i = 0; i < b; i++) begin
        chk("byp_pc", bus.disp_pc[i*32 +: 32], m_pc + 32'(4 * i));
        chk("byp_inst", bus.disp_inst[i*32 +: 32], inst_of(m_pc + 32'(4 * i)));
      end
      skip = imin(b, rdy);
      for (int i = 0; i < skip; i++) note_disp(m_pc + 32'(4 * i));
      k = imin(p - skip, free_n);
      for (int i = skip; i < skip + k; i++) begin
        e.pc = m_pc + 32'(4 * i); e.inst = inst_of(e.pc); sb.push_back(e);
      end
      m_pc    = m_pc + 32'(4 * (skip + k));
      m_count = m_count + k;
    end else begin
      v = imin(m_count, DW);
      chk("disp_valid", bus.disp_valid, mask(v));
      for (int i = 0; i < v; i++) begin
        chk("disp_pc", bus.disp_pc[i*32 +: 32], sb[i].pc);
        chk("disp_inst", bus.disp_inst[i*32 +: 32], sb[i].inst);
      end
      d = imin(rdy, v);
      k = imin(p, free_n);
      for (int i = 0; i < d; i++) begin
        e = sb.pop_front();
        note_disp(e.pc);
      end
      for (int i = 0; i < k; i++) begin
        e.pc = m_pc + 32'(4 * i); e.inst = inst_of(e.pc); sb.push_back(e);
      end
      m_pc    = m_pc + 32'(4 * k);
      m_count = m_count + k - d;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.icache_valid = '0;
    bus.icache_data  = '0;
    bus.disp_ready   = '0;
    bus.take_branch  = 1'b0;
    bus.target_pc    = '0;
    model_reset(32'h0);
    repeat (2) @(posedge clock);
    #4;
    chk("rst_fq_count", bus.fq_count, 0);
    chk("rst_disp_valid", bus.disp_valid, 3'b000);
    chk("rst_stall", bus.fetch_stall, 1'b0);
    chk("rst_pc", bus.icache_addr[31:0], 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Full three-lane hit into an empty queue
    cycle(3'b111, 0, 0, 0);
    chk("t1_count", bus.fq_count, 3);
    chk("t1_pc", bus.icache_addr[31:0], 32'd12);

    // Lane after a miss is discarded
    cycle(3'b101, 0, 0, 0);
    chk("t2_count", bus.fq_count, 4);
    chk("t2_pc", bus.icache_addr[31:0], 32'd16);
    cycle(3'b000, 3, 0, 0);
    cycle(3'b000, 3, 0, 0);
    cycle(3'b000, 3, 0, 0);

    // Fill to full from pc 0
    cycle(3'b000, 0, 1, 32'h0);
    cycle(3'b111, 0, 0, 0);
    cycle(3'b111, 0, 0, 0);
    chk("t3_count6", bus.fq_count, 6);
    #4;
    chk("t3_stall", bus.fetch_stall, 1'b1);
    @(posedge clock);
    #1;
    bus.icache_valid = 3'b000;
    model_reset(32'h0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cycle(3'b111, 0, 0, 0);
    cycle(3'b111, 0, 0, 0);
    cycle(3'b111, 0, 0, 0);
    chk("t3_full", bus.fq_count, 8);
    chk("t3_pc32", bus.icache_addr[31:0], 32'd32);
    cycle(3'b011, 0, 0, 0);
    cycle(3'b000, 3, 0, 0);

    // Redirect with five entries in flight
    chk("t4_count5", bus.fq_count, 5);
    cycle(3'b111, 3, 1, 32'h100);
    chk("t4_count0", bus.fq_count, 0);
    chk("t4_pc", bus.icache_addr[31:0], 32'h100);

    // Steady stream, several queue wraps
    for (int c = 0; c < 40; c++) cycle(3'b111, 2, 0, 0);

    // Mid-stream reset discards everything
    bus.icache_valid = 3'b111;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset(32'h0);
    cycle(3'b000, 0, 0, 0);

    // Random mix of hit patterns, dispatch widths and redirects
    for (int c = 0; c < 150; c++)
      cycle(3'($urandom), $urandom_range(0, 3), ($urandom_range(0, 19) == 0),
            32'($urandom_range(0, 1023)) * 32'd4);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
